// File: rtl/fetch_stage.sv
// IF stage: drives the instruction-memory request bus, buffers one word
// for ID, and steers fetch around taken branches after the delay slot.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        id_allowin_in,
    output logic        if_valid_out,
    output logic [31:0] if_PC_out,
    output logic [31:0] if_NPC_out,
    output logic [31:0] if_NNPC_out,
    output logic [31:0] if_Instruct_out,
    input  logic        id_br_valid_in,
    input  logic        id_br_taken_in,
    input  logic [31:0] id_br_target_in,
    input  logic [31:0] id_br_dspc_in
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_buf_pc;
    logic [31:0] r_buf_inst;
    logic        r_valid;
    logic        r_pend;
    logic [31:0] r_tgt;
    logic [31:0] r_ds;
    logic        r_discard;

    logic        w_in_req;
    logic        w_in_wait;
    logic        w_fire;
    logic        w_hs;
    logic        w_cap;
    logic        w_pend;
    logic [31:0] w_tgt;
    logic [31:0] w_ds4;
    logic        w_sub;
    logic        w_kill;
    logic        w_hit_req;
    logic        w_hit_wait;
    logic        w_drop;
    logic        w_wr;
    logic        w_redir_idle;
    logic        w_pend_clr;

    assign w_in_req  = (r_state == S_REQ);
    assign w_in_wait = (r_state == S_WAIT);
    assign w_fire    = r_valid & id_allowin_in;
    assign w_hs      = inst_req & inst_addr_ok;

    // A redirect is visible in the same cycle ID presents it.
    assign w_cap  = id_br_valid_in & id_br_taken_in & ~r_pend;
    assign w_pend = r_pend | w_cap;
    assign w_tgt  = r_pend ? r_tgt : id_br_target_in;
    assign w_ds4  = (r_pend ? r_ds : id_br_dspc_in) + 32'd4;

    // Only the registered redirect steers the address bus.
    assign w_sub  = r_pend & (r_fetch_pc == (r_ds + 32'd4));
    assign w_kill = w_pend & r_valid & (r_buf_pc == w_ds4);

    assign w_hit_req  = w_cap & w_hs & (r_fetch_pc == w_ds4);
    assign w_hit_wait = w_cap & w_in_wait & (r_req_pc == w_ds4);

    assign w_drop = w_in_wait & inst_data_ok
                  & (r_discard | w_hit_wait);
    assign w_wr   = w_in_wait & inst_data_ok & ~w_drop;

    assign w_redir_idle = w_kill & w_in_req & ~w_hs;
    assign w_pend_clr   = (w_hs & w_sub) | w_drop | w_redir_idle;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_REQ: begin
                if (w_hs) begin
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    w_state_nx = S_REQ;
                end
            end
            default: w_state_nx = S_REQ;
        endcase
    end

    // Request outputs
    always_comb begin
        inst_req  = 1'b0;
        inst_addr = r_fetch_pc;
        if (w_sub) begin
            inst_addr = r_tgt;
        end
        if (rst_n && w_in_req && (!r_valid || w_fire) && !w_kill) begin
            inst_req = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
        end else begin
            if (w_drop) begin
                r_fetch_pc <= w_tgt;
            end else if (w_hs) begin
                r_fetch_pc <= inst_addr + 32'd4;
                r_req_pc   <= inst_addr;
            end else if (w_redir_idle) begin
                r_fetch_pc <= w_tgt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_buf_pc   <= RESET_PC;
            r_buf_inst <= 32'd0;
        end else begin
            if (w_wr) begin
                r_valid    <= 1'b1;
                r_buf_pc   <= r_req_pc;
                r_buf_inst <= inst_rdata;
            end else if (w_fire || w_kill) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend    <= 1'b0;
            r_tgt     <= 32'd0;
            r_ds      <= 32'd0;
            r_discard <= 1'b0;
        end else begin
            r_pend <= w_pend & ~w_pend_clr;
            if (w_cap) begin
                r_tgt <= id_br_target_in;
                r_ds  <= id_br_dspc_in;
            end
            if (w_drop) begin
                r_discard <= 1'b0;
            end else if (w_hit_req || (w_hit_wait && !inst_data_ok)) begin
                r_discard <= 1'b1;
            end
        end
    end

    assign if_valid_out    = r_valid;
    assign if_PC_out       = r_buf_pc;
    assign if_NPC_out      = r_buf_pc + 32'd4;
    assign if_NNPC_out     = r_buf_pc + 32'd8;
    assign if_Instruct_out = r_buf_inst;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a one-cycle memory model plus
// expected-PC queue popped on every IF->ID transfer.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_allowin_in;
    logic        if_valid_out;
    logic [31:0] if_PC_out;
    logic [31:0] if_NPC_out;
    logic [31:0] if_NNPC_out;
    logic [31:0] if_Instruct_out;
    logic        id_br_valid_in;
    logic        id_br_taken_in;
    logic [31:0] id_br_target_in;
    logic [31:0] id_br_dspc_in;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .id_allowin_in  (id_allowin_in),
        .if_valid_out   (if_valid_out),
        .if_PC_out      (if_PC_out),
        .if_NPC_out     (if_NPC_out),
        .if_NNPC_out    (if_NNPC_out),
        .if_Instruct_out(if_Instruct_out),
        .id_br_valid_in (id_br_valid_in),
        .id_br_taken_in (id_br_taken_in),
        .id_br_target_in(id_br_target_in),
        .id_br_dspc_in  (id_br_dspc_in)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          fires = 0;
    int          budget = 0;
    bit          mem_off = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] acc_q[$];
    logic        m_hs;
    logic [31:0] m_a;
    logic [31:0] mon_e;
    int          n0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Memory: accepts whenever addr_ok is high, answers next cycle.
    always begin
        @(negedge clk);
        #2;
        m_hs = rst_n && inst_req && inst_addr_ok;
        m_a  = inst_addr;
        if (m_hs) acc_q.push_back(m_a);
        @(posedge clk);
        #1;
        if (!mem_off) begin
            inst_data_ok = m_hs;
            inst_rdata   = m_hs ? mem_word(m_a) : 32'h0;
        end
    end

    // Transfer monitor: a fire will happen at the coming posedge.
    always begin
        @(negedge clk);
        #3;
        if (rst_n && if_valid_out && id_allowin_in) begin
            fires++;
            if (exp_q.size() == 0) begin
                chk("sb_extra", if_PC_out, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_pc", if_PC_out, mon_e);
                chk("sb_npc", if_NPC_out, mon_e + 32'd4);
                chk("sb_nnpc", if_NNPC_out, mon_e + 32'd8);
                chk("sb_inst", if_Instruct_out, mem_word(mon_e));
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        id_allowin_in = (fires < budget);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        budget = 0;
        fires = 0;
        id_br_valid_in = 1'b0;
        id_br_taken_in = 1'b0;
        cyc();
        cyc();
        #1;
        chk("rst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid_out}, 32'd0);
        chk("rst_pc", if_PC_out, RST_PC);
        chk("rst_npc", if_NPC_out, RST_PC + 32'd4);
        chk("rst_nnpc", if_NNPC_out, RST_PC + 32'd8);
        chk("rst_inst", if_Instruct_out, 32'd0);
        cyc();
        rst_n = 1'b1;
        acc_q.delete();
    endtask

    task automatic run_to(input int b, input int maxc);
        budget = b;
        for (int i = 0; i < maxc && fires < b; i++) cyc();
        chk("fires", fires, b);
        chk("drain", exp_q.size(), 32'd0);
    endtask

    task automatic branch(input logic tk, input logic [31:0] tgt,
                          input logic [31:0] ds);
        id_br_valid_in  = 1'b1;
        id_br_taken_in  = tk;
        id_br_target_in = tgt;
        id_br_dspc_in   = ds;
        cyc();
        id_br_valid_in = 1'b0;
        id_br_taken_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        inst_addr_ok = 1'b1;
        inst_data_ok = 1'b0;
        inst_rdata = 32'h0;
        id_allowin_in = 1'b0;
        id_br_valid_in = 1'b0;
        id_br_taken_in = 1'b0;
        id_br_target_in = 32'h0;
        id_br_dspc_in = 32'h0;

        // Sequential fetch and first-word latency
        do_reset();
        cyc();
        #1;
        chk("lat_v0", {31'd0, if_valid_out}, 32'd0);
        cyc();
        #1;
        chk("lat_v1", {31'd0, if_valid_out}, 32'd1);
        chk("lat_pc", if_PC_out, RST_PC);
        chk("full_noreq", {31'd0, inst_req}, 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(RST_PC + 32'(4 * i));
        run_to(4, 40);
        chk("addr0", acc_q[0], RST_PC);
        chk("addr1", acc_q[1], RST_PC + 32'h4);
        chk("addr2", acc_q[2], RST_PC + 32'h8);

        // ID back-pressure
        cyc();
        cyc();
        cyc();
        #1;
        chk("bp_req", {31'd0, inst_req}, 32'd0);
        chk("bp_valid", {31'd0, if_valid_out}, 32'd1);
        chk("bp_pc", if_PC_out, RST_PC + 32'h10);
        cyc();
        cyc();
        #1;
        chk("bp_pc2", if_PC_out, RST_PC + 32'h10);
        chk("bp_req2", {31'd0, inst_req}, 32'd0);
        exp_q.push_back(RST_PC + 32'h10);
        exp_q.push_back(RST_PC + 32'h14);
        run_to(6, 30);
        chk("bp_next", acc_q[5], RST_PC + 32'h14);

        // Memory address stall
        inst_addr_ok = 1'b0;
        exp_q.push_back(RST_PC + 32'h18);
        exp_q.push_back(RST_PC + 32'h1C);
        budget = 8;
        for (int i = 0; i < 20; i++) begin
            cyc();
            #1;
            if (inst_req) break;
        end
        chk("st_addr0", inst_addr, RST_PC + 32'h1C);
        n0 = acc_q.size();
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            chk("st_req", {31'd0, inst_req}, 32'd1);
            chk("st_addr", inst_addr, RST_PC + 32'h1C);
        end
        chk("st_noacc", acc_q.size(), n0);
        inst_addr_ok = 1'b1;
        run_to(8, 30);

        // Taken branch after the ds+4 request was accepted
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(RST_PC + 32'(4 * i));
        exp_q.push_back(RST_PC + 32'h100);
        exp_q.push_back(RST_PC + 32'h104);
        budget = 8;
        for (int i = 0; i < 60; i++) begin
            cyc();
            #1;
            if (inst_req && inst_addr_ok && inst_addr == RST_PC + 32'h18)
                break;
        end
        cyc();
        branch(1'b1, RST_PC + 32'h100, RST_PC + 32'h14);
        run_to(8, 60);
        chk("disc_a6", acc_q[6], RST_PC + 32'h18);
        chk("disc_a7", acc_q[7], RST_PC + 32'h100);

        // Taken branch captured before the ds+4 request
        do_reset();
        branch(1'b1, RST_PC + 32'h100, RST_PC + 32'h8);
        exp_q.push_back(RST_PC);
        exp_q.push_back(RST_PC + 32'h4);
        exp_q.push_back(RST_PC + 32'h8);
        exp_q.push_back(RST_PC + 32'h100);
        exp_q.push_back(RST_PC + 32'h104);
        run_to(5, 60);
        chk("sub_a2", acc_q[2], RST_PC + 32'h8);
        chk("sub_a3", acc_q[3], RST_PC + 32'h100);

        // Not-taken branch
        do_reset();
        branch(1'b0, RST_PC + 32'h100, RST_PC + 32'h8);
        for (int i = 0; i < 5; i++) exp_q.push_back(RST_PC + 32'(4 * i));
        run_to(5, 60);
        chk("nt_a3", acc_q[3], RST_PC + 32'hC);

        // Redirect near the top of the address space wraps to zero
        do_reset();
        branch(1'b1, 32'hFFFF_FFFC, RST_PC + 32'h4);
        exp_q.push_back(RST_PC);
        exp_q.push_back(RST_PC + 32'h4);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        run_to(5, 60);
        chk("wrap_a3", acc_q[3], 32'h0);

        // Reset while waiting, stale response afterwards
        do_reset();
        mem_off = 1'b1;
        inst_data_ok = 1'b0;
        cyc();
        rst_n = 1'b0;
        inst_addr_ok = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        inst_data_ok = 1'b1;
        inst_rdata = 32'hDEAD_BEEF;
        cyc();
        inst_data_ok = 1'b0;
        #1;
        chk("stale_v", {31'd0, if_valid_out}, 32'd0);
        chk("stale_req", {31'd0, inst_req}, 32'd1);
        chk("stale_addr", inst_addr, RST_PC);
        cyc();
        #1;
        chk("stale_v2", {31'd0, if_valid_out}, 32'd0);
        mem_off = 1'b0;
        inst_addr_ok = 1'b1;
        exp_q.push_back(RST_PC);
        run_to(1, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
